// File: rtl/pgr_fifo_param_top.sv
// Parametrised first-word-fall-through FIFO with occupancy count,
// almost-full/almost-empty flags, synchronous flush and sticky overflow.
// Storage is a D-entry RAM followed by a registered head (rd_data/rd_valid).
// "DRM" adds a RAM read stage in front of the head register.
module pgr_fifo_param_top #(
  parameter int    W      = 8,
  parameter int    D      = 1024,
  parameter int    AF_LVL = D - 4,
  parameter int    AE_LVL = 4,
  parameter string TYPE   = "Distributed"
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic [W-1:0]         wr_data,
  input  logic                 wr_req,
  output logic                 wr_ready,
  input  logic                 rd_req,
  output logic [W-1:0]         rd_data,
  output logic                 rd_valid,
  output logic [$clog2(D):0]   count,
  output logic                 almost_full,
  output logic                 almost_empty,
  output logic                 ovf_err
);

  localparam int AW = $clog2(D);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] ram_cnt;
  logic [CW-1:0] count_nxt;
  logic          wr_fire;
  logic          rd_fire;
  logic          issue;
  logic          ram_nonempty;

  assign wr_fire      = wr_req & wr_ready & ~flush;
  assign rd_fire      = rd_req & rd_valid & ~flush;
  assign ram_nonempty = (ram_cnt != '0);

  // Next occupancy; flush wins over any simultaneous transfer
  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + CW'(wr_fire) - CW'(rd_fire);
  end

  // Occupancy, ready and flag registers, all derived from next-count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count        <= '0;
      wr_ready     <= 1'b0;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      ovf_err      <= 1'b0;
    end else begin
      count        <= count_nxt;
      wr_ready     <= (count_nxt < CW'(D));
      almost_full  <= (count_nxt >= CW'(AF_LVL));
      almost_empty <= (count_nxt <= CW'(AE_LVL));
      if (flush)
        ovf_err <= 1'b0;
      else if (wr_req && !wr_ready)
        ovf_err <= 1'b1;
    end
  end

  // RAM write port (no reset on storage)
  always_ff @(posedge clk) begin
    if (wr_fire)
      mem[wptr] <= wr_data;
  end

  // Write pointer and count of words still resident in RAM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      ram_cnt <= '0;
    end else if (flush) begin
      wptr    <= '0;
      ram_cnt <= '0;
    end else begin
      if (wr_fire)
        wptr <= wptr + AW'(1);
      ram_cnt <= ram_cnt + CW'(wr_fire) - CW'(issue);
    end
  end

  if (TYPE == "DRM") begin : g_drm
    logic [W-1:0] q_data;
    logic         q_valid;
    logic         q_move;

    // Read stage hands its word to the head whenever the head is empty or
    // being consumed; a new RAM read is issued whenever that stage will be
    // free, so a consumer reading every cycle still gets one word per cycle.
    always_comb begin
      q_move = q_valid & (~rd_valid | rd_fire);
      issue  = ram_nonempty & (~q_valid | q_move) & ~flush;
    end

    // Synchronous RAM read (block RAM output register)
    always_ff @(posedge clk) begin
      if (issue)
        q_data <= mem[rptr];
    end

    // Read pointer, read-stage valid and head register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rptr     <= '0;
        q_valid  <= 1'b0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (flush) begin
        rptr     <= '0;
        q_valid  <= 1'b0;
        rd_valid <= 1'b0;
      end else begin
        if (issue)
          rptr <= rptr + AW'(1);
        q_valid <= issue | (q_valid & ~q_move);
        if (q_move) begin
          rd_data  <= q_data;
          rd_valid <= 1'b1;
        end else if (rd_fire) begin
          rd_valid <= 1'b0;
        end
      end
    end
  end else begin : g_dist
    // Head loads straight from the async-read RAM when empty or consumed
    always_comb begin
      issue = ram_nonempty & (~rd_valid | rd_fire) & ~flush;
    end

    // Read pointer and head register
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rptr     <= '0;
        rd_valid <= 1'b0;
        rd_data  <= '0;
      end else if (flush) begin
        rptr     <= '0;
        rd_valid <= 1'b0;
      end else if (issue) begin
        rd_data  <= mem[rptr];
        rd_valid <= 1'b1;
        rptr     <= rptr + AW'(1);
      end else if (rd_fire) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule
